vliw_hazard_ctrl: RTL and testbench
===================================

Name: vliw_hazard_ctrl

Overview:
Hazard and sequencing controller for the dual-slot (ALU slot + MEM slot) VLIW pipeline. Keeps a per-register scoreboard of pending load results for the 8-entry register file. Decides, per bundle in ID, whether to issue, stall, or squash it. Drives the PC, IF/ID and ID/EX enables, bubble insertion, and the flushes on taken branches or jumps resolved in EX.

Parameters:
LOAD_LAT, 1, number of cycles a load result is unavailable to a directly following dependent bundle (legal range 0..3)
NREG, 8, architectural registers; fixed by the 3-bit specifiers
CNT_W, 2, scoreboard counter width; must hold LOAD_LAT

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high
id_valid  in  1  IF/ID holds a real bundle
id_alu_rm, id_alu_rn  in  3 each  ALU-slot source specifiers
id_alu_useRm, id_alu_useRn  in  1 each  the corresponding source is actually read
id_alu_rd  in  3  ALU-slot destination
id_alu_regWrite  in  1  ALU slot writes id_alu_rd
id_mem_rn, id_mem_rd  in  3 each  MEM-slot base register and data/destination register
id_memRead, id_memWrite, id_mem_regWrite  in  1 each  MEM-slot controls, from the control circuit
ex_branchTaken  in  1  branch or jump in EX resolved taken
pc_write  out  1  PC load enable
p1_pipeline_regWrite  out  1  IF/ID write enable
id_bubble  out  1  force the ID/EX control signals to NOP
IF_flush, ID_flush  out  1 each  squash the IF/ID and ID/EX contents
kill_mem_regWrite  out  1  suppress the MEM-slot register write for this bundle
waw_conflict  out  1  both slots write the same rd in this bundle
stall  out  1  a hazard stall is active this cycle
stall_count  out  16  saturating count of stall cycles

Behaviour:
- Scoreboard: cnt[0..7], each CNT_W bits wide, reset to 0.
- Source usage for a bundle:
  - ALU slot reads rm and rn when the corresponding use flag is set.
  - MEM slot reads rn when id_memRead or id_memWrite is set.
  - MEM slot reads rd when id_memWrite is set (store data).
- hazard = id_valid AND (any used source r has cnt[r] != 0).
- FSM states: RUN, STALL, SHADOW. Reset state is RUN.
- Redirect condition: redirect = ex_branchTaken AND state != SHADOW.
- Redirect has priority over everything. In the same cycle (combinational):
  - IF_flush=1, ID_flush=1, pc_write=1, p1_pipeline_regWrite=1, id_bubble=1, stall=0.
  - No scoreboard reservation is made.
  - Next state is SHADOW.
- SHADOW lasts exactly 1 cycle. In SHADOW, ex_branchTaken is ignored because EX holds the squashed bubble. Otherwise SHADOW evaluates like RUN.
- Stall (hazard and no redirect):
  - pc_write=0, p1_pipeline_regWrite=0, id_bubble=1, stall=1.
  - Next state is STALL.
  - stall_count increments and saturates at 0xFFFF.
- Issue (no hazard and no redirect):
  - pc_write=1, p1_pipeline_regWrite=1, id_bubble=0.
  - Next state is RUN.
  - If id_memRead AND id_mem_regWrite, set cnt[id_mem_rd] = LOAD_LAT.
- ALU results are fully forwarded and never reserve a scoreboard entry.
- Counter update, every cycle: each nonzero cnt decrements by 1. A reservation made in the same cycle overrides the decrement for that entry.
- Stall length: with LOAD_LAT=L, a dependent bundle immediately after a load stalls exactly L cycles. L=0 gives no stalls.
- WAW in one bundle: id_valid AND id_alu_regWrite AND id_mem_regWrite AND id_alu_rd==id_mem_rd.
  - waw_conflict=1 and kill_mem_regWrite=1; the ALU write wins.
  - No load reservation is made for the killed write.
  - This is combinational, and is valid only when the bundle issues.
- Same-bundle read-after-write is not a hazard: both slots read pre-bundle register values.
- When id_valid=0, hazard=0 and no reservation is made.
- Reset values: FSM state RUN, all cnt=0, stall_count=0.
- Outputs while reset is asserted: pc_write=1, p1_pipeline_regWrite=1, id_bubble=0, flushes=0, stall=0.
- Reset mid-stall or mid-redirect discards all state immediately.

Decomposition:
- Shared package vliw_pkg: REG_W=3, NREG=8, the FSM state encoding (RUN, STALL, SHADOW), and the NOP control-bundle constant.
- One sub-module, vliw_scoreboard: the cnt array with reserve/decrement logic and a 3-port busy lookup (alu_rm, alu_rn, mem_rn/rd).
- The FSM, WAW detection and stall counter stay in the top level.

Test Plan:
- LOAD_LAT=1: load to r3 issues, next bundle's ALU slot reads r3 -> stall=1 for 1 cycle, pc_write=0, id_bubble=1, then issue; stall_count=1.
- LOAD_LAT=2: load to r5, next bundle stores r5 (mem rd) -> 2 stall cycles. Repeat with an independent bundle between them -> 1 stall cycle.
- ex_branchTaken during a load-use stall -> same-cycle IF_flush=ID_flush=1, pc_write=1, stall=0, no reservation. ex_branchTaken=1 in the following SHADOW cycle -> ignored.
- Bundle with ALU rd=r2 and load rd=r2 -> waw_conflict=1, kill_mem_regWrite=1, cnt[2] stays 0, and a dependent next bundle does not stall.
- Assert reset asynchronously mid-stall with cnt[4]=1 -> outputs return to reset values before the next edge, and a reader of r4 after reset issues without stall.
- Force 70000 consecutive stalls -> stall_count saturates at 0xFFFF.

Source files
------------

// File: rtl/vliw_hazard_ctrl_pkg.sv
// Shared definitions for the dual-slot VLIW hazard controller: register
// file geometry, controller FSM encoding and the control bits of a bundle
// as seen by the load scoreboard.
package vliw_pkg;

  localparam int REG_W = 3;
  localparam int NREG  = 8;

  localparam logic [15:0] STALL_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STALL  = 2'd1,
    SHADOW = 2'd2
  } hzState_t;

  // Control bits of the bundle leaving ID that decide a load reservation.
  typedef struct packed {
    logic memRead;
    logic memRegWrite;
  } bundleCtrl_t;

  // What ID/EX carries when a bubble is inserted.
  localparam bundleCtrl_t NOP_BUNDLE = '0;

  // Saturating increment for the stall statistics counter.
  function automatic logic [15:0] satInc16(input logic [15:0] v);
    return (v == STALL_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/vliw_hazard_ctrl_if.sv
// Bundle-in-ID descriptor plus the pipeline steering outputs exchanged
// between the ID stage (master) and the hazard controller (slave).
interface vliw_hazard_ctrl_if;
  import vliw_pkg::*;

  logic             id_valid;
  logic [REG_W-1:0] id_alu_rm;
  logic [REG_W-1:0] id_alu_rn;
  logic             id_alu_useRm;
  logic             id_alu_useRn;
  logic [REG_W-1:0] id_alu_rd;
  logic             id_alu_regWrite;
  logic [REG_W-1:0] id_mem_rn;
  logic [REG_W-1:0] id_mem_rd;
  logic             id_memRead;
  logic             id_memWrite;
  logic             id_mem_regWrite;
  logic             ex_branchTaken;

  logic             pc_write;
  logic             p1_pipeline_regWrite;
  logic             id_bubble;
  logic             IF_flush;
  logic             ID_flush;
  logic             kill_mem_regWrite;
  logic             waw_conflict;
  logic             stall;
  logic [15:0]      stall_count;

  modport master (
    output id_valid, id_alu_rm, id_alu_rn, id_alu_useRm, id_alu_useRn,
           id_alu_rd, id_alu_regWrite, id_mem_rn, id_mem_rd, id_memRead,
           id_memWrite, id_mem_regWrite, ex_branchTaken,
    input  pc_write, p1_pipeline_regWrite, id_bubble, IF_flush, ID_flush,
           kill_mem_regWrite, waw_conflict, stall, stall_count
  );

  modport slave (
    input  id_valid, id_alu_rm, id_alu_rn, id_alu_useRm, id_alu_useRn,
           id_alu_rd, id_alu_regWrite, id_mem_rn, id_mem_rd, id_memRead,
           id_memWrite, id_mem_regWrite, ex_branchTaken,
    output pc_write, p1_pipeline_regWrite, id_bubble, IF_flush, ID_flush,
           kill_mem_regWrite, waw_conflict, stall, stall_count
  );

endinterface

// File: rtl/vliw_hazard_ctrl_scoreboard.sv
// Per-register countdown of outstanding load results. A nonzero count means
// a bundle reading that register in ID would see a stale value.
module vliw_scoreboard
  import vliw_pkg::*;
#(
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             reserve,
  input  logic [REG_W-1:0] reserveReg,
  input  logic [REG_W-1:0] qAluRm,
  input  logic [REG_W-1:0] qAluRn,
  input  logic [REG_W-1:0] qMemRn,
  input  logic [REG_W-1:0] qMemRd,
  output logic             busyAluRm,
  output logic             busyAluRn,
  output logic             busyMemRn,
  output logic             busyMemRd
);

  localparam logic [CNT_W-1:0] LAT = CNT_W'(LOAD_LAT);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt [NREG];

  // Reload the reserved entry, otherwise count every pending entry down.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (reserve && (reserveReg == REG_W'(i))) begin
          cnt[i] <= LAT;
        end else if (cnt[i] != '0) begin
          cnt[i] <= cnt[i] - ONE;
        end
      end
    end
  end

  // Busy lookups for every register a bundle can read.
  always_comb begin
    busyAluRm = (cnt[qAluRm] != '0);
    busyAluRn = (cnt[qAluRn] != '0);
    busyMemRn = (cnt[qMemRn] != '0);
    busyMemRd = (cnt[qMemRd] != '0);
  end

endmodule

// File: rtl/vliw_hazard_ctrl.sv
// Hazard and sequencing controller for the ALU+MEM VLIW pipeline: decides
// per ID bundle between issue, load-use stall and redirect squash, detects
// same-bundle write collisions and keeps a saturating stall statistic.
module vliw_hazard_ctrl
  import vliw_pkg::*;
#(
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 2
) (
  input logic              clk,
  input logic              reset,
  vliw_hazard_ctrl_if.slave hz
);

  hzState_t    state;
  hzState_t    nextState;
  logic [15:0] stallCount;

  logic        busyAluRm;
  logic        busyAluRn;
  logic        busyMemRn;
  logic        busyMemRd;
  logic        useMemRn;
  logic        useMemRd;
  logic        hazard;
  logic        redirect;
  logic        waw;
  logic        issue;
  logic        reserve;
  bundleCtrl_t rawCtrl;
  bundleCtrl_t issuedCtrl;

  vliw_scoreboard #(
    .LOAD_LAT (LOAD_LAT),
    .CNT_W    (CNT_W)
  ) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .reserve    (reserve),
    .reserveReg (hz.id_mem_rd),
    .qAluRm     (hz.id_alu_rm),
    .qAluRn     (hz.id_alu_rn),
    .qMemRn     (hz.id_mem_rn),
    .qMemRd     (hz.id_mem_rd),
    .busyAluRm  (busyAluRm),
    .busyAluRn  (busyAluRn),
    .busyMemRn  (busyMemRn),
    .busyMemRd  (busyMemRd)
  );

  // Both slots read pre-bundle register values, so only loads from earlier
  // bundles can make a source stale. A killed MEM write never reserves.
  always_comb begin
    useMemRn   = hz.id_memRead | hz.id_memWrite;
    useMemRd   = hz.id_memWrite;
    waw        = hz.id_valid & hz.id_alu_regWrite & hz.id_mem_regWrite &
                 (hz.id_alu_rd == hz.id_mem_rd);
    hazard     = hz.id_valid & ((hz.id_alu_useRm & busyAluRm) |
                                (hz.id_alu_useRn & busyAluRn) |
                                (useMemRn & busyMemRn) |
                                (useMemRd & busyMemRd));
    redirect   = hz.ex_branchTaken & (state != SHADOW);
    issue      = ~reset & ~redirect & ~hazard & hz.id_valid;
    rawCtrl    = '{memRead: hz.id_memRead, memRegWrite: hz.id_mem_regWrite & ~waw};
    issuedCtrl = issue ? rawCtrl : NOP_BUNDLE;
    reserve    = issuedCtrl.memRead & issuedCtrl.memRegWrite;
  end

  assign hz.waw_conflict      = waw;
  assign hz.kill_mem_regWrite = waw;

  // Controller state register; reset drops any stall or shadow at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= nextState;
  end

  // Redirect beats stall beats issue; SHADOW only masks the squashed branch.
  always_comb begin
    nextState               = RUN;
    hz.pc_write             = 1'b1;
    hz.p1_pipeline_regWrite = 1'b1;
    hz.id_bubble            = 1'b0;
    hz.IF_flush             = 1'b0;
    hz.ID_flush             = 1'b0;
    hz.stall                = 1'b0;
    if (!reset) begin
      if (redirect) begin
        hz.IF_flush  = 1'b1;
        hz.ID_flush  = 1'b1;
        hz.id_bubble = 1'b1;
        nextState    = SHADOW;
      end else if (hazard) begin
        hz.pc_write             = 1'b0;
        hz.p1_pipeline_regWrite = 1'b0;
        hz.id_bubble            = 1'b1;
        hz.stall                = 1'b1;
        nextState               = STALL;
      end
    end
  end

  // Saturating count of cycles spent stalled on load-use hazards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         stallCount <= '0;
    else if (hz.stall) stallCount <= satInc16(stallCount);
  end

  assign hz.stall_count = stallCount;

endmodule

// File: tb/tb_vliw_hazard_ctrl.sv
// Randomised and directed bench for vliw_hazard_ctrl. Four controllers run
// side by side (LOAD_LAT 1, 2, 3, 0) against a ready-time reference model.
module tb_vliw_hazard_ctrl;

  typedef struct packed {
    logic       valid;
    logic [2:0] rm;
    logic [2:0] rn;
    logic [2:0] rd;
    logic       useRm;
    logic       useRn;
    logic       aluW;
    logic [2:0] mrn;
    logic [2:0] mrd;
    logic       mr;
    logic       mw;
    logic       mW;
    logic       br;
  } bnd_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  rstV = 4'hF;
  bnd_t        drv  [4];
  logic [23:0] outs [4];

  int errors = 0;
  int checks = 0;

  // Reference model: a register is readable from cycle readyAt onwards.
  int readyAt  [4][8];
  bit shadow   [4];
  int stallCnt [4];
  int cyc      [4];

  function automatic int latOf(int d);
    return (d == 3) ? 0 : d + 1;
  endfunction

  for (genvar i = 0; i < 4; i++) begin : g
    vliw_hazard_ctrl_if hzIf ();
    vliw_hazard_ctrl #(.LOAD_LAT((i == 3) ? 0 : i + 1), .CNT_W(2)) dut (
      .clk   (clk),
      .reset (rstV[i]),
      .hz    (hzIf)
    );
    assign hzIf.id_valid        = drv[i].valid;
    assign hzIf.id_alu_rm       = drv[i].rm;
    assign hzIf.id_alu_rn       = drv[i].rn;
    assign hzIf.id_alu_useRm    = drv[i].useRm;
    assign hzIf.id_alu_useRn    = drv[i].useRn;
    assign hzIf.id_alu_rd       = drv[i].rd;
    assign hzIf.id_alu_regWrite = drv[i].aluW;
    assign hzIf.id_mem_rn       = drv[i].mrn;
    assign hzIf.id_mem_rd       = drv[i].mrd;
    assign hzIf.id_memRead      = drv[i].mr;
    assign hzIf.id_memWrite     = drv[i].mw;
    assign hzIf.id_mem_regWrite = drv[i].mW;
    assign hzIf.ex_branchTaken  = drv[i].br;
    assign outs[i] = {hzIf.pc_write, hzIf.p1_pipeline_regWrite, hzIf.id_bubble,
                      hzIf.IF_flush, hzIf.ID_flush, hzIf.stall,
                      hzIf.waw_conflict, hzIf.kill_mem_regWrite, hzIf.stall_count};
  end

  task automatic checkEq(string tag, int d, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h", tag, d, cyc[d], got, exp);
    end
  endtask

  task automatic resetModel(int d);
    for (int r = 0; r < 8; r++) readyAt[d][r] = 0;
    shadow[d]   = 1'b0;
    stallCnt[d] = 0;
  endtask

  function automatic bit isBusy(int d, logic [2:0] r);
    return cyc[d] < readyAt[d][r];
  endfunction

  function automatic bnd_t mkLoad(logic [2:0] rd, logic [2:0] base);
    bnd_t b = '0;
    b.valid = 1'b1; b.mr = 1'b1; b.mW = 1'b1; b.mrd = rd; b.mrn = base;
    return b;
  endfunction

  function automatic bnd_t mkRead(logic [2:0] r);
    bnd_t b = '0;
    b.valid = 1'b1; b.useRm = 1'b1; b.rm = r;
    return b;
  endfunction

  function automatic bnd_t mkStore(logic [2:0] data, logic [2:0] base);
    bnd_t b = '0;
    b.valid = 1'b1; b.mw = 1'b1; b.mrd = data; b.mrn = base;
    return b;
  endfunction

  function automatic bnd_t mkRand();
    bnd_t b;
    b.valid = ($urandom_range(7) != 0);
    b.rm    = 3'($urandom_range(3));
    b.rn    = 3'($urandom_range(3));
    b.rd    = 3'($urandom_range(3));
    b.useRm = 1'($urandom_range(1));
    b.useRn = 1'($urandom_range(1));
    b.aluW  = 1'($urandom_range(1));
    b.mrn   = 3'($urandom_range(3));
    b.mrd   = 3'($urandom_range(3));
    b.mr    = 1'($urandom_range(1));
    b.mw    = ($urandom_range(3) == 0);
    b.mW    = 1'($urandom_range(1));
    b.br    = ($urandom_range(9) == 0);
    return b;
  endfunction

  // One ID cycle: drive after the edge, check at the falling edge, advance model.
  task automatic step(int d, bnd_t b, bit doCheck);
    bit       hzd, redir, waw;
    bit [5:0] ctl;
    @(posedge clk); #1;
    drv[d] = b;
    @(negedge clk);
    hzd = b.valid && ((b.useRm && isBusy(d, b.rm)) || (b.useRn && isBusy(d, b.rn)) ||
                      ((b.mr || b.mw) && isBusy(d, b.mrn)) || (b.mw && isBusy(d, b.mrd)));
    redir = b.br && !shadow[d];
    waw   = b.valid && b.aluW && b.mW && (b.rd == b.mrd);
    if (redir)    ctl = 6'b111110;
    else if (hzd) ctl = 6'b001001;
    else          ctl = 6'b110000;
    if (doCheck) begin
      checkEq("ctrl", d, 32'(outs[d][23:16]), 32'({ctl, waw, waw}));
      checkEq("stallCount", d, 32'(outs[d][15:0]), 32'(stallCnt[d]));
    end
    if (!redir && !hzd && b.valid && b.mr && b.mW && !waw)
      readyAt[d][b.mrd] = cyc[d] + latOf(d) + 1;
    if (!redir && hzd && stallCnt[d] < 65535) stallCnt[d]++;
    shadow[d] = redir;
    cyc[d]++;
  endtask

  task automatic doReset(int d);
    @(posedge clk); #1;
    drv[d]  = '0;
    rstV[d] = 1'b1;
    #1;
    checkEq("rstCtrl", d, 32'(outs[d][23:16]), 32'h0C0);
    checkEq("rstStallCount", d, 32'(outs[d][15:0]), 32'd0);
    resetModel(d);
    @(posedge clk); #1;
    rstV[d] = 1'b0;
  endtask

  task automatic runA();
    bnd_t b;
    doReset(0);
    step(0, mkLoad(3, 0), 1'b1);
    step(0, mkRead(3), 1'b1);
    step(0, mkRead(3), 1'b1);
    checkEq("loadUseStallCnt", 0, 32'(outs[0][15:0]), 32'd1);
    b = mkLoad(2, 1); b.aluW = 1'b1; b.rd = 3'd2;
    step(0, b, 1'b1);
    step(0, mkRead(2), 1'b1);
    for (int i = 0; i < 600; i++) begin
      if (i == 300) doReset(0);
      step(0, mkRand(), 1'b1);
    end
  endtask

  task automatic runB();
    bnd_t b;
    doReset(1);
    step(1, mkLoad(5, 0), 1'b1);
    repeat (3) step(1, mkStore(5, 1), 1'b1);
    step(1, mkLoad(5, 0), 1'b1);
    step(1, mkRead(1), 1'b1);
    repeat (2) step(1, mkStore(5, 1), 1'b1);
    step(1, mkLoad(6, 0), 1'b1);
    b = mkRead(6); b.br = 1'b1; b.mr = 1'b1; b.mW = 1'b1; b.mrd = 3'd7;
    step(1, b, 1'b1);
    b = mkRead(7); b.br = 1'b1;
    step(1, b, 1'b1);
    step(1, mkRead(6), 1'b1);
    b = '0; b.br = 1'b1;
    step(1, b, 1'b1);
    step(1, mkLoad(4, 0), 1'b1);
    step(1, mkRead(4), 1'b1);
    #1 rstV[1] = 1'b1;
    #1;
    checkEq("asyncRstCtrl", 1, 32'(outs[1][23:16]), 32'h0C0);
    checkEq("asyncRstStallCount", 1, 32'(outs[1][15:0]), 32'd0);
    resetModel(1);
    #1 rstV[1] = 1'b0;
    step(1, mkRead(4), 1'b1);
    for (int i = 0; i < 600; i++) step(1, mkRand(), 1'b1);
  endtask

  task automatic runC();
    bnd_t b;
    doReset(2);
    b = mkLoad(3, 0); b.useRm = 1'b1; b.rm = 3'd3;
    for (int i = 0; i < 88000; i++) step(2, b, (i % 8192) < 6);
    step(2, b, 1'b1);
    checkEq("stallSat", 2, 32'(outs[2][15:0]), 32'h0000FFFF);
  endtask

  task automatic runD();
    doReset(3);
    step(3, mkLoad(1, 0), 1'b1);
    step(3, mkRead(1), 1'b1);
    for (int i = 0; i < 400; i++) step(3, mkRand(), 1'b1);
    checkEq("zeroLatNoStall", 3, 32'(outs[3][15:0]), 32'd0);
  endtask

  initial begin
    for (int d = 0; d < 4; d++) begin
      drv[d] = '0;
      cyc[d] = 0;
      resetModel(d);
    end
    fork
      runA();
      runB();
      runC();
      runD();
    join
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "time limit");
  end

endmodule
